// File: rtl/sort_pkg.sv
// Shared sorter geometry: element width N and elements per frame W.
package sort_pkg;
    localparam int N  = 8;
    localparam int W  = 4;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    typedef logic [W-1:0][N-1:0] frame_t;
endpackage

// File: rtl/sort_drain.sv
// Deskews skewed sorter rows into whole frames, buffers DEPTH frames, streams elements by rank.
// Latency: first beat W+1 cycles after i_vld; 1 beat/cycle sustained.
// Backpressure: outputs hold while o_valid & !i_ready; full FIFO drops frames (o_ovf). Option: SORT_DRAIN_CHECK_EN.
module sort_drain
    import sort_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vld,
    input  logic [W-1:0][N-1:0]   i_y_q,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [N-1:0]          o_data,
    output logic [IW-1:0]         o_idx,
    output logic                  o_last,
    output logic                  o_ovf,
    output logic                  o_order_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [W-1:0]  vchain;
    frame_t        aligned;
    logic          aln_vld;

    frame_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, nxt_ptr;
    logic [PW:0]   level, remain;

    logic          acc, pop, full, push, drop, load, nxt_avail;
    frame_t        nxt_frame;

    logic [0:0]    state, state_d;
    logic          valid_d, last_d;
    logic [N-1:0]  data_d;
    logic [IW-1:0] idx_d;

    // Tap i is high in the cycle row i of a frame is on i_y_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vchain <= '0;
        end else begin
            vchain[0] <= i_vld;
            for (int i = 1; i < W; i++) vchain[i] <= vchain[i-1];
        end
    end

    for (genvar r = 0; r < W - 1; r++) begin : g_row
        localparam int D = W - 1 - r;
        logic [D-1:0][N-1:0] dly;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dly <= '0;
            end else begin
                if (vchain[r]) dly[0] <= i_y_q[r];
                for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
            end
        end
        assign aligned[r] = dly[D-1];
    end
    assign aligned[W-1] = i_y_q[W-1];
    assign aln_vld      = vchain[W-1];

    assign acc  = o_valid & i_ready;
    assign pop  = acc & o_last;
    assign full = (level == (PW+1)'(DEPTH));
    assign push = aln_vld & (!full | pop);
    assign drop = aln_vld & full & !pop;

    // Next frame comes from the FIFO if one remains after the pop, else straight from the deskew.
    assign remain    = level - (PW+1)'(pop);
    assign nxt_ptr   = rd_ptr + PW'(pop);
    assign nxt_frame = (remain != '0) ? mem[nxt_ptr] : aligned;
    assign nxt_avail = (remain != '0) | push;
    assign load      = (state == ST_IDLE) | pop;

    always_comb begin
        state_d = state;
        valid_d = o_valid;
        data_d  = o_data;
        idx_d   = o_idx;
        last_d  = o_last;
        if (load) begin
            idx_d = '0;
            if (nxt_avail) begin
                state_d = ST_SEND;
                valid_d = 1'b1;
                data_d  = nxt_frame[0];
                last_d  = (W == 1);
            end else begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end else if (acc) begin
            idx_d  = o_idx + 1'b1;
            data_d = mem[rd_ptr][idx_d];
            last_d = (idx_d == IW'(W - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= aligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level   <= level + (PW+1)'(push) - (PW+1)'(pop);
            state   <= state_d;
            o_valid <= valid_d;
            o_data  <= data_d;
            o_idx   <= idx_d;
            o_last  <= last_d;
            if (drop) o_ovf <= 1'b1;
        end
    end

`ifdef SORT_DRAIN_CHECK_EN
    logic [N-1:0] prev_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_data   <= '0;
            o_order_err <= 1'b0;
        end else if (acc) begin
            prev_data <= o_data;
            if (o_idx != '0 && o_data < prev_data) o_order_err <= 1'b1;
        end
    end
`else
    assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_drain.sv
// Directed bench for sort_drain (W=4, DEPTH=4) with a beat scoreboard.
module tb_sort_drain;
    import sort_pkg::*;

`ifdef SORT_DRAIN_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_vld = 1'b0;
    logic          i_ready = 1'b0;
    frame_t        i_y_q = '0;
    logic          o_valid;
    logic [N-1:0]  o_data;
    logic [IW-1:0] o_idx;
    logic          o_last;
    logic          o_ovf;
    logic          o_order_err;

    always #5 clk = ~clk;

    sort_drain #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vld       (i_vld),
        .i_y_q       (i_y_q),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_idx       (o_idx),
        .o_last      (o_last),
        .o_ovf       (o_ovf),
        .o_order_err (o_order_err)
    );

    int passed = 0;
    int total  = 0;
    int g      = 0;
    logic          vld_h [0:4095];
    frame_t        frm_h [0:4095];
    logic [IW+N:0] exp_q [$];
    frame_t        fr [0:4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    function automatic frame_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [N-1:0] c, input logic [N-1:0] d);
        frame_t f;
        f[0] = a; f[1] = b; f[2] = c; f[3] = d;
        return f;
    endfunction

    task automatic expect_frame(input frame_t f);
        for (int k = 0; k < W; k++) exp_q.push_back({(k == W - 1), IW'(k), f[k]});
    endtask

    // One clock cycle: drive i_vld/i_ready and the skewed rows, then check outputs mid-cycle.
    task automatic tick(input logic v, input frame_t f, input logic rdy);
        @(posedge clk);
        #1;
        g++;
        vld_h[g] = v;
        frm_h[g] = f;
        i_vld    = v;
        i_ready  = rdy;
        for (int r = 0; r < W; r++)
            i_y_q[r] = (g - r - 1 >= 0 && vld_h[g-r-1]) ? frm_h[g-r-1][r] : N'(8'hEE);
        @(negedge clk);
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'(o_valid), 32'd0);
            end else begin
                check("beat", 32'({o_last, o_idx, o_data}), 32'(exp_q[0]));
                if (i_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) tick(1'b0, '0, rdy);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_data"},  32'(o_data),  32'd0);
        check({tag, "_idx"},   32'(o_idx),   32'd0);
        check({tag, "_last"},  32'(o_last),  32'd0);
        check({tag, "_ovf"},   32'(o_ovf),   32'd0);
        check({tag, "_oerr"},  32'(o_order_err), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) vld_h[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Single frame: beats at cycles 5..8 relative to i_vld.
        tick(1'b1, mk(8'd3, 8'd7, 8'd9, 8'd12), 1'b1);
        expect_frame(mk(8'd3, 8'd7, 8'd9, 8'd12));
        idle(4, 1'b1);
        check("t1_early", 32'(o_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1, 1'b1);
            check("t1_valid", 32'(o_valid), 32'd1);
        end
        idle(1, 1'b1);
        check("t1_done", 32'(o_valid), 32'd0);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Three back-to-back frames: 12 beats with no gap.
        idle(3, 1'b1);
        tick(1'b1, mk(8'd1, 8'd2, 8'd3, 8'd4), 1'b1);
        tick(1'b1, mk(8'd10, 8'd20, 8'd30, 8'd40), 1'b1);
        tick(1'b1, mk(8'd5, 8'd6, 8'd7, 8'd8), 1'b1);
        expect_frame(mk(8'd1, 8'd2, 8'd3, 8'd4));
        expect_frame(mk(8'd10, 8'd20, 8'd30, 8'd40));
        expect_frame(mk(8'd5, 8'd6, 8'd7, 8'd8));
        idle(2, 1'b1);
        check("t2_early", 32'(o_valid), 32'd0);
        for (int k = 0; k < 12; k++) begin
            idle(1, 1'b1);
            check("t2_nogap", 32'(o_valid), 32'd1);
        end
        idle(1, 1'b1);
        check("t2_done", 32'(o_valid), 32'd0);
        check("t2_ovf", 32'(o_ovf), 32'd0);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Full FIFO with the last head beat accepted as a new frame aligns: no drop.
        for (int k = 0; k < 5; k++)
            fr[k] = mk(8'(16*k+1), 8'(16*k+2), 8'(16*k+3), 8'(16*k+4));
        idle(3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, fr[k], 1'b0);
            expect_frame(fr[k]);
        end
        idle(4, 1'b0);
        tick(1'b1, fr[4], 1'b0);
        expect_frame(fr[4]);
        for (int k = 0; k < 20; k++) begin
            idle(1, 1'b1);
            check("tf_stream", 32'(o_valid), 32'd1);
        end
        idle(1, 1'b1);
        check("tf_done", 32'(o_valid), 32'd0);
        check("tf_ovf", 32'(o_ovf), 32'd0);
        check("tf_drained", 32'(exp_q.size()), 32'd0);

        // Five frames into a stalled 4-deep FIFO: fifth dropped, sticky o_ovf.
        for (int k = 0; k < 5; k++)
            fr[k] = mk(8'(16*k+5), 8'(16*k+6), 8'(16*k+7), 8'(16*k+8));
        idle(3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, fr[k], 1'b0);
            if (k < 4) expect_frame(fr[k]);
        end
        idle(4, 1'b0);
        check("t3_ovf_before", 32'(o_ovf), 32'd0);
        idle(1, 1'b0);
        check("t3_ovf_set", 32'(o_ovf), 32'd1);
        idle(3, 1'b0);
        check("t3_hold_valid", 32'(o_valid), 32'd1);
        for (int k = 0; k < 16; k++) begin
            idle(1, 1'b1);
            check("t3_stream", 32'(o_valid), 32'd1);
        end
        idle(1, 1'b1);
        check("t3_done", 32'(o_valid), 32'd0);
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_ovf_sticky", 32'(o_ovf), 32'd1);

        // i_ready toggling: every element once, in order, held during stalls.
        idle(3, 1'b1);
        tick(1'b1, mk(8'd11, 8'd22, 8'd33, 8'd44), 1'b1);
        tick(1'b1, mk(8'd50, 8'd60, 8'd70, 8'd80), 1'b0);
        expect_frame(mk(8'd11, 8'd22, 8'd33, 8'd44));
        expect_frame(mk(8'd50, 8'd60, 8'd70, 8'd80));
        for (int k = 0; k < 30; k++) idle(1, logic'(k % 2));
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two frames buffered and a third in the deskew.
        idle(3, 1'b1);
        tick(1'b1, mk(8'd90, 8'd91, 8'd92, 8'd93), 1'b0);
        tick(1'b1, mk(8'd94, 8'd95, 8'd96, 8'd97), 1'b0);
        expect_frame(mk(8'd90, 8'd91, 8'd92, 8'd93));
        expect_frame(mk(8'd94, 8'd95, 8'd96, 8'd97));
        idle(3, 1'b0);
        tick(1'b1, mk(8'd98, 8'd99, 8'd100, 8'd101), 1'b0);
        idle(1, 1'b0);
        check("t5_buffered", 32'(o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("t5_rst");
        exp_q.delete();
        idle(2, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            idle(1, 1'b1);
            check("t5_no_stale", 32'(o_valid), 32'd0);
        end

        // Out-of-order rows flag o_order_err only when the checker is built in.
        tick(1'b1, mk(8'd5, 8'd2, 8'd8, 8'd9), 1'b1);
        expect_frame(mk(8'd5, 8'd2, 8'd8, 8'd9));
        idle(6, 1'b1);
        check("t6_oerr_before", 32'(o_order_err), 32'd0);
        idle(1, 1'b1);
        check("t6_oerr_after", 32'(o_order_err), 32'(ERR_EXP));
        idle(3, 1'b1);
        check("t6_oerr_sticky", 32'(o_order_err), 32'(ERR_EXP));
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
